fpdiv_seq: RTL and testbench

Sequential IEEE-754 binary32 divider with valid/ready handshakes on its input and output. It replaces the combinational fpdiv wherever the divide must be pipelined against a clock, and it is the responder driven by the vector-replay driver. The divider uses a restoring radix-2 iteration, handles subnormals, supports all four rounding modes, and reports exception flags.

---
 rtl/fpdiv_seq.sv | 243 ++++++++++++++++++++++++
 tb/tb_fpdiv_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_seq.sv
// Sequential IEEE-754 binary32 divider: restoring radix-2 quotient iteration with
// valid/ready handshakes, subnormal support, four rounding modes and exception flags.
module fpdiv_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [1:0]  round_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [4:0]  flags
);
    localparam int unsigned ITERS = 26;
    localparam int unsigned SIG_W = 24;
    localparam int unsigned EXP_W = 10;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned SH_W  = 6;
    localparam int unsigned WIDE_W = 50;

    localparam logic [1:0]  RNE  = 2'b00;
    localparam logic [1:0]  RZ   = 2'b01;
    localparam logic [1:0]  RDN  = 2'b10;
    localparam logic [31:0] QNAN = 32'h7fc0_0000;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;

    state_t                  state;
    logic [31:0]             a_q, b_q;
    logic [1:0]              mode_q;
    logic                    sign_q;
    logic [SIG_W-1:0]        md_q;
    logic [ITERS-1:0]        rem_q, quo_q;
    logic signed [EXP_W-1:0] exp_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    spec_q;
    logic [31:0]             spec_res_q;
    logic [4:0]              spec_flg_q;

    function automatic logic [4:0] lzc24(input logic [SIG_W-1:0] m);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (m[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    function automatic logic round_inc(input logic [1:0] m, input logic s,
                                       input logic lsb, input logic g, input logic st);
        logic r;
        case (m)
            RNE:     r = g & (st | lsb);
            RZ:      r = 1'b0;
            RDN:     r = s & (g | st);
            default: r = ~s & (g | st);
        endcase
        return r;
    endfunction

    // Operand unpack, subnormal normalisation and special-case classification
    logic [7:0]              en_raw_c, ed_raw_c;
    logic [22:0]             fn_c, fd_c;
    logic [4:0]              lzn_c, lzd_c;
    logic [SIG_W-1:0]        mn_c, md_c;
    logic signed [EXP_W-1:0] en_c, ed_c;
    logic                    nan_n_c, nan_d_c, snan_c, inf_n_c, inf_d_c, zero_n_c, zero_d_c;
    logic                    sgn_c, spec_c;
    logic [31:0]             spec_res_c;
    logic [4:0]              spec_flg_c;

    always_comb begin
        en_raw_c = a_q[30:23];
        ed_raw_c = b_q[30:23];
        fn_c     = a_q[22:0];
        fd_c     = b_q[22:0];
        lzn_c    = lzc24({1'b0, fn_c});
        lzd_c    = lzc24({1'b0, fd_c});
        mn_c     = {1'b1, fn_c};
        md_c     = {1'b1, fd_c};
        en_c     = signed'(EXP_W'(en_raw_c));
        ed_c     = signed'(EXP_W'(ed_raw_c));
        if (en_raw_c == 8'd0) begin
            mn_c = {1'b0, fn_c} << lzn_c;
            en_c = 10'sd1 - signed'(EXP_W'(lzn_c));
        end
        if (ed_raw_c == 8'd0) begin
            md_c = {1'b0, fd_c} << lzd_c;
            ed_c = 10'sd1 - signed'(EXP_W'(lzd_c));
        end

        nan_n_c  = (en_raw_c == 8'hff) && (fn_c != 23'd0);
        nan_d_c  = (ed_raw_c == 8'hff) && (fd_c != 23'd0);
        snan_c   = (nan_n_c && !fn_c[22]) || (nan_d_c && !fd_c[22]);
        inf_n_c  = (en_raw_c == 8'hff) && (fn_c == 23'd0);
        inf_d_c  = (ed_raw_c == 8'hff) && (fd_c == 23'd0);
        zero_n_c = (a_q[30:0] == 31'd0);
        zero_d_c = (b_q[30:0] == 31'd0);
        sgn_c    = a_q[31] ^ b_q[31];

        spec_c     = 1'b1;
        spec_res_c = QNAN;
        spec_flg_c = 5'b00000;
        if (nan_n_c || nan_d_c) begin
            spec_flg_c = {snan_c, 4'b0000};
        end else if ((zero_n_c && zero_d_c) || (inf_n_c && inf_d_c)) begin
            spec_flg_c = 5'b10000;
        end else if (inf_n_c) begin
            spec_res_c = {sgn_c, 8'hff, 23'd0};
        end else if (zero_d_c) begin
            spec_res_c = {sgn_c, 8'hff, 23'd0};
            spec_flg_c = 5'b01000;
        end else if (inf_d_c || zero_n_c) begin
            spec_res_c = {sgn_c, 31'd0};
        end else begin
            spec_c = 1'b0;
        end
    end

    // One restoring step: trial subtract of the divisor significand
    logic [ITERS:0]   diff_c;
    logic [ITERS-1:0] rem_keep_c;
    always_comb begin
        diff_c     = {1'b0, rem_q} - {3'b000, md_q};
        rem_keep_c = diff_c[ITERS] ? rem_q : diff_c[ITERS-1:0];
    end

    // Normalise, denormalise into sticky, round and pack
    logic                    qn_c, g0_c, st0_c, g1_c, st1_c, inc_c, inc_u_c;
    logic                    tiny_path_c, tiny_c, ovf_c, nx_c, uf_c;
    logic [SIG_W-1:0]        sig0_c, sig1_c;
    logic signed [EXP_W-1:0] e0_c, sh_full_c, e_fin_c;
    logic [SH_W-1:0]         sh_c;
    logic [WIDE_W-1:0]       wide_c;
    logic [SIG_W:0]          sum_c;
    logic [22:0]             frac_c;
    logic [31:0]             res_c;
    logic [4:0]              flg_c;

    always_comb begin
        qn_c   = quo_q[ITERS-1];
        sig0_c = qn_c ? quo_q[25:2] : quo_q[24:1];
        g0_c   = qn_c ? quo_q[1] : quo_q[0];
        st0_c  = (qn_c & quo_q[0]) | (rem_q != '0);
        e0_c   = qn_c ? exp_q : exp_q - 10'sd1;

        tiny_path_c = (e0_c < 10'sd1);
        sh_full_c   = 10'sd1 - e0_c;
        sh_c        = '0;
        if (tiny_path_c) begin
            sh_c = (sh_full_c > 10'sd26) ? SH_W'(26) : sh_full_c[SH_W-1:0];
        end
        wide_c = {sig0_c, g0_c, 25'd0} >> sh_c;
        sig1_c = wide_c[49:26];
        g1_c   = wide_c[25];
        st1_c  = st0_c | (wide_c[24:0] != 25'd0);

        inc_c = round_inc(mode_q, sign_q, sig1_c[0], g1_c, st1_c);
        sum_c = {1'b0, sig1_c} + (SIG_W+1)'(inc_c);

        // Tininess judged on the unbounded-exponent rounding of the full significand
        inc_u_c = round_inc(mode_q, sign_q, sig0_c[0], g0_c, st0_c);
        tiny_c  = tiny_path_c && !((e0_c == 10'sd0) && (&sig0_c) && inc_u_c);

        e_fin_c = tiny_path_c ? signed'(EXP_W'(sum_c[23])) : e0_c + signed'(EXP_W'(sum_c[24]));
        frac_c  = sum_c[24] ? 23'd0 : sum_c[22:0];
        ovf_c   = !tiny_path_c && (e_fin_c >= 10'sd255);
        nx_c    = g1_c | st1_c;
        uf_c    = tiny_c & nx_c;

        res_c = {sign_q, e_fin_c[7:0], frac_c};
        flg_c = {3'b000, uf_c, nx_c};
        if (spec_q) begin
            res_c = spec_res_q;
            flg_c = spec_flg_q;
        end else if (ovf_c) begin
            flg_c = 5'b00101;
            case (mode_q)
                RNE:     res_c = {sign_q, 8'hff, 23'd0};
                RZ:      res_c = {sign_q, 8'hfe, 23'h7fffff};
                RDN:     res_c = sign_q ? 32'hff80_0000 : 32'h7f7f_ffff;
                default: res_c = sign_q ? 32'hff7f_ffff : 32'h7f80_0000;
            endcase
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            flags     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= dividend;
                        b_q      <= divisor;
                        mode_q   <= round_mode;
                        in_ready <= 1'b0;
                        state    <= S_PREP;
                    end
                end
                S_PREP: begin
                    sign_q     <= sgn_c;
                    md_q       <= md_c;
                    rem_q      <= ITERS'(mn_c);
                    quo_q      <= '0;
                    exp_q      <= en_c - ed_c + 10'sd127;
                    spec_q     <= spec_c;
                    spec_res_q <= spec_res_c;
                    spec_flg_q <= spec_flg_c;
                    cnt_q      <= '0;
                    state      <= S_ITER;
                end
                S_ITER: begin
                    rem_q <= {rem_keep_c[ITERS-2:0], 1'b0};
                    quo_q <= {quo_q[ITERS-2:0], ~diff_c[ITERS]};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == CNT_W'(ITERS - 1)) state <= S_ROUND;
                end
                S_ROUND: begin
                    quotient  <= res_c;
                    flags     <= flg_c;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpdiv_seq.sv
// Directed bench for fpdiv_seq: vector table for results, flags and latency,
// plus hand-written output-hold and mid-operation reset sequences.
module tb_fpdiv_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [1:0]  round_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] quotient;
    logic [4:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  m;
        logic [31:0] q;
        logic [4:0]  f;
    } vec_t;

    vec_t vecs[$];

    fpdiv_seq dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .round_mode(round_mode),
        .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    function automatic void add(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                                input logic [31:0] q, input logic [4:0] f);
        vec_t v;
        v.a = a; v.b = b; v.m = m; v.q = q; v.f = f;
        vecs.push_back(v);
    endfunction

    // Issue one operation, wait for the result, then complete the output handshake
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                         output logic [31:0] q, output logic [4:0] f,
                         output int lat, output logic ir_seen);
        int w = 0;
        while (!in_ready && w < 200) begin
            @(posedge clk); #1; w++;
        end
        dividend = a; divisor = b; round_mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        ir_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (in_ready) ir_seen = 1'b1;
        end
        q = quotient;
        f = flags;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] q, q_hold;
        logic [4:0]  f, f_hold;
        int          lat;
        logic        ir_seen;
        logic        ov_seen;

        // flags = {NV, DZ, OF, UF, NX}
        add(32'h3f800000, 32'h40000000, 2'b00, 32'h3f000000, 5'h00);
        add(32'h3f800000, 32'h40400000, 2'b00, 32'h3eaaaaab, 5'h01);
        add(32'h3f800000, 32'h40400000, 2'b01, 32'h3eaaaaaa, 5'h01);
        add(32'h3f800000, 32'h40400000, 2'b10, 32'h3eaaaaaa, 5'h01);
        add(32'h3f800000, 32'h40400000, 2'b11, 32'h3eaaaaab, 5'h01);
        add(32'hbf800000, 32'h40400000, 2'b10, 32'hbeaaaaab, 5'h01);
        add(32'hbf800000, 32'h40400000, 2'b11, 32'hbeaaaaaa, 5'h01);
        add(32'h40c00000, 32'h40000000, 2'b00, 32'h40400000, 5'h00);
        add(32'h3f800000, 32'h00000000, 2'b00, 32'h7f800000, 5'h08);
        add(32'h00000000, 32'h00000000, 2'b00, 32'h7fc00000, 5'h10);
        add(32'h7fa00000, 32'h3f800000, 2'b00, 32'h7fc00000, 5'h10);
        add(32'h7fc00000, 32'h3f800000, 2'b00, 32'h7fc00000, 5'h00);
        add(32'hbf800000, 32'h7f800000, 2'b00, 32'h80000000, 5'h00);
        add(32'h7f800000, 32'h3f800000, 2'b00, 32'h7f800000, 5'h00);
        add(32'h7f800000, 32'h7f800000, 2'b00, 32'h7fc00000, 5'h10);
        add(32'h7f7fffff, 32'h3e800000, 2'b00, 32'h7f800000, 5'h05);
        add(32'h7f7fffff, 32'h3e800000, 2'b01, 32'h7f7fffff, 5'h05);
        add(32'h7f7fffff, 32'h3e800000, 2'b10, 32'h7f7fffff, 5'h05);
        add(32'h7f7fffff, 32'h3e800000, 2'b11, 32'h7f800000, 5'h05);
        add(32'hff7fffff, 32'h3e800000, 2'b10, 32'hff800000, 5'h05);
        add(32'h00800000, 32'h40000000, 2'b00, 32'h00400000, 5'h00);
        add(32'h00000001, 32'h3f000000, 2'b00, 32'h00000002, 5'h00);
        add(32'h00000001, 32'h40000000, 2'b00, 32'h00000000, 5'h03);
        add(32'h00000001, 32'h40000000, 2'b11, 32'h00000001, 5'h03);
        add(32'h00000001, 32'h40000000, 2'b01, 32'h00000000, 5'h03);
        add(32'h00ffffff, 32'h40000000, 2'b00, 32'h00800000, 5'h03);

        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset quotient", quotient, 32'h0);
        check("reset flags", 32'(flags), 32'h0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].m, q, f, lat, ir_seen);
            check($sformatf("v%0d %h/%h m%0d quotient", i, vecs[i].a, vecs[i].b, vecs[i].m), q, vecs[i].q);
            check($sformatf("v%0d flags", i), 32'(f), 32'(vecs[i].f));
            check($sformatf("v%0d latency", i), 32'(lat), 32'd28);
            check($sformatf("v%0d in_ready busy", i), 32'(ir_seen), 32'd0);
            check($sformatf("v%0d in_ready after", i), 32'(in_ready), 32'd1);
        end

        // Result held while the consumer stalls
        dividend = 32'h3f800000; divisor = 32'h40400000; round_mode = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check("hold latency", 32'(lat), 32'd28);
        q_hold = quotient;
        f_hold = flags;
        check("hold first quotient", q_hold, 32'h3eaaaaab);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold c%0d quotient", k), quotient, 32'h3eaaaaab);
            check($sformatf("hold c%0d flags", k), 32'(flags), 32'h01);
            check($sformatf("hold c%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold c%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release in_ready", 32'(in_ready), 32'd1);
        check("release out_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of the iteration aborts the operation
        dividend = 32'h40c00000; divisor = 32'h40000000; round_mode = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset in_ready", 32'(in_ready), 32'd1);
        ov_seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (out_valid) ov_seen = 1'b1;
        end
        check("midreset no result", 32'(ov_seen), 32'd0);
        do_op(32'h3f800000, 32'h40000000, 2'b00, q, f, lat, ir_seen);
        check("post-reset quotient", q, 32'h3f000000);
        check("post-reset flags", 32'(f), 32'h0);
        check("post-reset latency", 32'(lat), 32'd28);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
